// File: rtl/axis_test.sv
// Matrix-multiply accelerator C = A x B over AXI4-Stream: buffers A and B,
// computes C tile by tile on a P x Q MAC array, then streams C row-major.
module axis_test #(
    parameter int M  = 25,
    parameter int N  = 19,
    parameter int L  = 17,
    parameter int DW = 8,
    parameter int OW = 16,
    parameter int P  = 8,
    parameter int Q  = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          mode,
    input  logic [DW-1:0] s_axis_a_tdata,
    input  logic          s_axis_a_tvalid,
    output logic          s_axis_a_tready,
    input  logic          s_axis_a_tlast,
    input  logic [DW-1:0] s_axis_b_tdata,
    input  logic          s_axis_b_tvalid,
    output logic          s_axis_b_tready,
    input  logic          s_axis_b_tlast,
    output logic [OW-1:0] m_axis_c_tdata,
    output logic          m_axis_c_tvalid,
    input  logic          m_axis_c_tready,
    output logic          m_axis_c_tlast,
    output logic [1:0]    dbg_state
);
    // Handshake: a beat moves on a rising edge where tvalid && tready are both
    // high; m_axis_c_tdata/tlast hold stable while tvalid is high and tready low.

    localparam int A_SZ = M * N;
    localparam int B_SZ = N * L;
    localparam int C_SZ = M * L;
    localparam int TR   = (M + P - 1) / P;
    localparam int TC   = (L + Q - 1) / Q;
    localparam int AW   = $clog2(A_SZ + 1);
    localparam int BW   = $clog2(B_SZ + 1);
    localparam int AIW  = (A_SZ > 1) ? $clog2(A_SZ) : 1;
    localparam int BIW  = (B_SZ > 1) ? $clog2(B_SZ) : 1;
    localparam int CIW  = (C_SZ > 1) ? $clog2(C_SZ) : 1;
    localparam int KW   = $clog2(N + 1);
    localparam int TRW  = (TR > 1) ? $clog2(TR) : 1;
    localparam int TCW  = (TC > 1) ? $clog2(TC) : 1;

    localparam logic [AW-1:0]  A_FULL  = AW'(A_SZ);
    localparam logic [AW-1:0]  A_LAST  = AW'(A_SZ - 1);
    localparam logic [BW-1:0]  B_FULL  = BW'(B_SZ);
    localparam logic [BW-1:0]  B_LAST  = BW'(B_SZ - 1);
    localparam logic [CIW-1:0] C_LAST  = CIW'(C_SZ - 1);
    localparam logic [KW-1:0]  K_N     = KW'(N);
    localparam logic [TRW-1:0] TR_LAST = TRW'(TR - 1);
    localparam logic [TCW-1:0] TC_LAST = TCW'(TC - 1);

    typedef enum logic [1:0] {S_LOAD, S_COMPUTE, S_PRIME, S_OUTPUT} state_t;

    state_t         state;
    logic [AW-1:0]  a_cnt;
    logic [BW-1:0]  b_cnt;
    logic [CIW-1:0] out_idx;
    logic [CIW-1:0] out_nxt;
    logic [KW-1:0]  step;
    logic [TRW-1:0] tr;
    logic [TCW-1:0] tc;
    logic           mode_q;

    logic [DW-1:0]  a_mem [A_SZ];
    logic [DW-1:0]  b_mem [B_SZ];
    logic [OW-1:0]  c_mem [C_SZ];
    logic [OW-1:0]  acc   [P][Q];
    logic [OW-1:0]  a_op  [P];
    logic [OW-1:0]  b_op  [Q];
    logic           c_en  [P][Q];
    logic [CIW-1:0] c_idx [P][Q];

    logic a_fire, b_fire, unused_tlast;

    assign a_fire       = s_axis_a_tvalid && s_axis_a_tready;
    assign b_fire       = s_axis_b_tvalid && s_axis_b_tready;
    assign out_nxt      = out_idx + 1'b1;
    assign dbg_state    = state;
    assign unused_tlast = s_axis_a_tlast ^ s_axis_b_tlast;

    // Operands are widened to OW bits so one OW x OW multiply gives the
    // product modulo 2^OW for both signed and unsigned modes.
    function automatic logic [OW-1:0] widen(input logic [DW-1:0] v, input logic sgn);
        return sgn ? {{(OW-DW){v[DW-1]}}, v} : {{(OW-DW){1'b0}}, v};
    endfunction

    always_comb begin
        for (int r = 0; r < P; r++) begin
            a_op[r] = '0;
            if ((int'(tr) * P + r) < M && step != K_N)
                a_op[r] = widen(a_mem[AIW'((int'(tr) * P + r) * N + int'(step))], mode_q);
        end
        for (int c = 0; c < Q; c++) begin
            b_op[c] = '0;
            if ((int'(tc) * Q + c) < L && step != K_N)
                b_op[c] = widen(b_mem[BIW'(int'(step) * L + int'(tc) * Q + c)], mode_q);
        end
        for (int r = 0; r < P; r++) begin
            for (int c = 0; c < Q; c++) begin
                c_en[r][c]  = ((int'(tr) * P + r) < M) && ((int'(tc) * Q + c) < L);
                c_idx[r][c] = c_en[r][c] ? CIW'((int'(tr) * P + r) * L + int'(tc) * Q + c) : '0;
            end
        end
    end

    // Storage and MAC array; no reset needed since counters gate every use.
    always_ff @(posedge clk) begin
        if (a_fire) a_mem[AIW'(a_cnt)] <= s_axis_a_tdata;
        if (b_fire) b_mem[BIW'(b_cnt)] <= s_axis_b_tdata;
        if (state == S_COMPUTE) begin
            if (step != K_N) begin
                for (int r = 0; r < P; r++)
                    for (int c = 0; c < Q; c++)
                        acc[r][c] <= ((step == '0) ? '0 : acc[r][c]) + a_op[r] * b_op[c];
            end else begin
                for (int r = 0; r < P; r++)
                    for (int c = 0; c < Q; c++)
                        if (c_en[r][c]) c_mem[c_idx[r][c]] <= acc[r][c];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state           <= S_LOAD;
            a_cnt           <= '0;
            b_cnt           <= '0;
            out_idx         <= '0;
            step            <= '0;
            tr              <= '0;
            tc              <= '0;
            mode_q          <= 1'b0;
            s_axis_a_tready <= 1'b1;
            s_axis_b_tready <= 1'b1;
            m_axis_c_tvalid <= 1'b0;
            m_axis_c_tlast  <= 1'b0;
            m_axis_c_tdata  <= '0;
        end else begin
            case (state)
                S_LOAD: begin
                    if (a_fire) begin
                        a_cnt <= a_cnt + 1'b1;
                        if (a_cnt == A_LAST) s_axis_a_tready <= 1'b0;
                    end
                    if (b_fire) begin
                        b_cnt <= b_cnt + 1'b1;
                        if (b_cnt == B_LAST) s_axis_b_tready <= 1'b0;
                    end
                    if (a_cnt == A_FULL && b_cnt == B_FULL) begin
                        state  <= S_COMPUTE;
                        mode_q <= mode;
                        step   <= '0;
                        tr     <= '0;
                        tc     <= '0;
                    end
                end
                // N accumulate steps per tile, then one step writing the tile out.
                S_COMPUTE: begin
                    if (step != K_N) begin
                        step <= step + 1'b1;
                    end else begin
                        step <= '0;
                        if (tc == TC_LAST) begin
                            tc <= '0;
                            if (tr == TR_LAST) begin
                                tr    <= '0;
                                state <= S_PRIME;
                            end else begin
                                tr <= tr + 1'b1;
                            end
                        end else begin
                            tc <= tc + 1'b1;
                        end
                    end
                end
                S_PRIME: begin
                    out_idx         <= '0;
                    m_axis_c_tdata  <= c_mem[0];
                    m_axis_c_tvalid <= 1'b1;
                    m_axis_c_tlast  <= (C_SZ == 1);
                    state           <= S_OUTPUT;
                end
                S_OUTPUT: begin
                    if (m_axis_c_tready) begin
                        if (out_idx == C_LAST) begin
                            m_axis_c_tvalid <= 1'b0;
                            m_axis_c_tlast  <= 1'b0;
                            m_axis_c_tdata  <= '0;
                            out_idx         <= '0;
                            a_cnt           <= '0;
                            b_cnt           <= '0;
                            s_axis_a_tready <= 1'b1;
                            s_axis_b_tready <= 1'b1;
                            state           <= S_LOAD;
                        end else begin
                            out_idx        <= out_nxt;
                            m_axis_c_tdata <= c_mem[out_nxt];
                            m_axis_c_tlast <= (out_nxt == C_LAST);
                        end
                    end
                end
                default: state <= S_LOAD;
            endcase
        end
    end
endmodule

// File: tb/tb_axis_test.sv
// Bench for axis_test: directed scenarios with random data and backpressure,
// checked against a plain-arithmetic matrix product model.
module tb_axis_test;
    localparam int M = 25, N = 19, L = 17, DW = 8, OW = 16, P = 8, Q = 8;
    localparam int A_SZ = M * N, B_SZ = N * L, C_SZ = M * L;

    logic          clk = 0;
    logic          rst_n = 1;
    logic          mode = 0;
    logic [DW-1:0] s_axis_a_tdata = '0;
    logic          s_axis_a_tvalid = 0, s_axis_a_tlast = 0;
    logic          s_axis_a_tready;
    logic [DW-1:0] s_axis_b_tdata = '0;
    logic          s_axis_b_tvalid = 0, s_axis_b_tlast = 0;
    logic          s_axis_b_tready;
    logic [OW-1:0] m_axis_c_tdata;
    logic          m_axis_c_tvalid, m_axis_c_tlast;
    logic          m_axis_c_tready = 0;
    logic [1:0]    dbg_state;

    axis_test #(.M(M), .N(N), .L(L), .DW(DW), .OW(OW), .P(P), .Q(Q)) dut (
        .clk(clk), .rst_n(rst_n), .mode(mode),
        .s_axis_a_tdata(s_axis_a_tdata), .s_axis_a_tvalid(s_axis_a_tvalid),
        .s_axis_a_tready(s_axis_a_tready), .s_axis_a_tlast(s_axis_a_tlast),
        .s_axis_b_tdata(s_axis_b_tdata), .s_axis_b_tvalid(s_axis_b_tvalid),
        .s_axis_b_tready(s_axis_b_tready), .s_axis_b_tlast(s_axis_b_tlast),
        .m_axis_c_tdata(m_axis_c_tdata), .m_axis_c_tvalid(m_axis_c_tvalid),
        .m_axis_c_tready(m_axis_c_tready), .m_axis_c_tlast(m_axis_c_tlast),
        .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    logic [DW-1:0] a_mat [A_SZ];
    logic [DW-1:0] b_mat [B_SZ];
    logic [OW-1:0] c_obs [C_SZ];
    logic [OW-1:0] exp_q [$];

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", name, obs, expv);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_checks++;
        n_fail++;
        $error("FAIL %s: timed out", name);
    endtask

    // kind 0: A=i+j, B=2i+j+1; 1: A=0xFF, B=0x02; 2: random; 3: identity-like A, random B
    task automatic fill(input int kind);
        for (int i = 0; i < M; i++)
            for (int j = 0; j < N; j++)
                case (kind)
                    0: a_mat[i*N+j] = DW'(i + j);
                    1: a_mat[i*N+j] = 8'hFF;
                    3: a_mat[i*N+j] = (i % N == j) ? 8'd1 : 8'd0;
                    default: a_mat[i*N+j] = DW'($urandom_range(255));
                endcase
        for (int i = 0; i < N; i++)
            for (int j = 0; j < L; j++)
                case (kind)
                    0: b_mat[i*L+j] = DW'(2 * i + j + 1);
                    1: b_mat[i*L+j] = 8'h02;
                    default: b_mat[i*L+j] = DW'($urandom_range(255));
                endcase
    endtask

    function automatic int elem(input logic [DW-1:0] v, input logic sgn);
        return sgn ? int'($signed(v)) : int'({24'b0, v});
    endfunction

    task automatic build_exp(input logic sgn);
        int s;
        exp_q.delete();
        for (int i = 0; i < M; i++)
            for (int j = 0; j < L; j++) begin
                s = 0;
                for (int k = 0; k < N; k++)
                    s += elem(a_mat[i*N+k], sgn) * elem(b_mat[k*L+j], sgn);
                exp_q.push_back(OW'(s));
            end
    endtask

    // Drivers change inputs at negedge; ready seen at negedge holds through the next posedge.
    task automatic drive_a(input int gap_pct);
        int t;
        logic rdy;
        for (int i = 0; i < A_SZ; i++) begin
            s_axis_a_tvalid = 0;
            while ($urandom_range(99) < gap_pct) @(negedge clk);
            s_axis_a_tdata  = a_mat[i];
            s_axis_a_tlast  = (i == A_SZ - 1) ^ (gap_pct > 0 && $urandom_range(15) == 0);
            s_axis_a_tvalid = 1;
            t = 0;
            forever begin
                rdy = s_axis_a_tready;
                @(negedge clk);
                t++;
                if (rdy || t > 2000) break;
            end
            if (!rdy) begin
                timeout_fail("a_beat");
                break;
            end
        end
        s_axis_a_tvalid = 0;
        s_axis_a_tlast  = 0;
    endtask

    task automatic drive_b(input int gap_pct);
        int t;
        logic rdy;
        for (int i = 0; i < B_SZ; i++) begin
            s_axis_b_tvalid = 0;
            while ($urandom_range(99) < gap_pct) @(negedge clk);
            s_axis_b_tdata  = b_mat[i];
            s_axis_b_tlast  = (i == B_SZ - 1) ^ (gap_pct > 0 && $urandom_range(15) == 0);
            s_axis_b_tvalid = 1;
            t = 0;
            forever begin
                rdy = s_axis_b_tready;
                @(negedge clk);
                t++;
                if (rdy || t > 2000) break;
            end
            if (!rdy) begin
                timeout_fail("b_beat");
                break;
            end
        end
        s_axis_b_tvalid = 0;
        s_axis_b_tlast  = 0;
    endtask

    task automatic collect(input int ready_pct);
        int got = 0, cyc = 0, nlast = 0;
        logic stalled = 0;
        logic [OW-1:0] held = '0, e;
        while (got < C_SZ && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            if (stalled) begin
                check("hold_valid", 32'(m_axis_c_tvalid), 32'd1);
                check("hold_data", 32'(m_axis_c_tdata), 32'(held));
            end
            stalled = 0;
            m_axis_c_tready = ($urandom_range(99) < ready_pct);
            if (m_axis_c_tvalid) begin
                if (m_axis_c_tready) begin
                    e = exp_q.pop_front();
                    check("c_data", 32'(m_axis_c_tdata), 32'(e));
                    check("c_last", 32'(m_axis_c_tlast), 32'(got == C_SZ - 1));
                    c_obs[got] = m_axis_c_tdata;
                    if (m_axis_c_tlast) nlast++;
                    got++;
                end else begin
                    stalled = 1;
                    held    = m_axis_c_tdata;
                end
            end
        end
        if (got < C_SZ) timeout_fail("c_stream");
        @(negedge clk);
        m_axis_c_tready = 0;
        check("c_valid_after", 32'(m_axis_c_tvalid), 32'd0);
        check("c_nlast", 32'(nlast), 32'd1);
        check("a_ready_reload", 32'(s_axis_a_tready), 32'd1);
        check("b_ready_reload", 32'(s_axis_b_tready), 32'd1);
    endtask

    task automatic run_pair(input int gap_pct, input int ready_pct);
        build_exp(mode);
        fork
            drive_a(gap_pct);
            drive_b(gap_pct);
        join
        collect(ready_pct);
    endtask

    initial begin
        int t, stale;
        // Reset
        repeat (3) @(negedge clk);
        rst_n = 0;
        check("rst_a_ready", 32'(s_axis_a_tready), 32'd1);
        check("rst_b_ready", 32'(s_axis_b_tready), 32'd1);
        check("rst_c_valid", 32'(m_axis_c_tvalid), 32'd0);
        check("rst_c_last", 32'(m_axis_c_tlast), 32'd0);
        check("rst_c_data", 32'(m_axis_c_tdata), 32'd0);

        // Arithmetic pattern, concurrent streams, sink always ready
        mode = 0;
        fill(0);
        run_pair(0, 100);
        check("c00", 32'(c_obs[0]), 32'd4389);
        check("c01", 32'(c_obs[1]), 32'd4560);
        check("c_last_elem", 32'(c_obs[C_SZ-1]), 32'd23085);

        // A first, idle gap, then B
        fill(0);
        build_exp(0);
        drive_a(0);
        check("a_ready_full", 32'(s_axis_a_tready), 32'd0);
        check("b_ready_wait", 32'(s_axis_b_tready), 32'd1);
        repeat (10) @(negedge clk);
        check("a_ready_idle", 32'(s_axis_a_tready), 32'd0);
        check("b_ready_idle", 32'(s_axis_b_tready), 32'd1);
        drive_b(0);
        check("b_ready_full", 32'(s_axis_b_tready), 32'd0);
        collect(100);

        // Extreme values, unsigned then signed
        mode = 0;
        fill(1);
        run_pair(10, 100);
        check("ff02_u", 32'(c_obs[C_SZ/2]), 32'h25DA);
        mode = 1;
        fill(1);
        run_pair(10, 100);
        check("ff02_s", 32'(c_obs[C_SZ/2]), 32'hFFDA);

        // Random data with source gaps and sink backpressure
        mode = 1;
        fill(2);
        run_pair(30, 40);
        mode = 0;
        fill(2);
        run_pair(20, 70);

        // Reset during COMPUTE, then a fresh pair
        mode = 1;
        fill(2);
        fork
            drive_a(20);
            drive_b(20);
        join
        t = 0;
        while (dbg_state != 2'd1 && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (dbg_state != 2'd1) timeout_fail("reach_compute");
        repeat (5) @(negedge clk);
        check("compute_a_ready", 32'(s_axis_a_tready), 32'd0);
        check("compute_b_ready", 32'(s_axis_b_tready), 32'd0);
        rst_n = 1;
        repeat (2) @(negedge clk);
        rst_n = 0;
        check("rst2_a_ready", 32'(s_axis_a_tready), 32'd1);
        check("rst2_b_ready", 32'(s_axis_b_tready), 32'd1);
        check("rst2_c_valid", 32'(m_axis_c_tvalid), 32'd0);
        stale = 0;
        repeat (300) begin
            @(negedge clk);
            if (m_axis_c_tvalid) stale++;
        end
        check("no_stale_output", 32'(stale), 32'd0);
        mode = 1'($urandom_range(1));
        fill(2);
        run_pair(25, 50);

        // Back-to-back pair with identity-like A
        mode = 0;
        fill(3);
        run_pair(0, 80);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
